// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, functs,
// state codes, ALU control codes and datapath select codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_IWB     = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ORIEX   = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode: maps the sequencer's aluop plus R-type funct to an
// ALU operation, flagging functs the ALU cannot execute.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_funct_valid
);

    // aluop/funct to ALU operation lookup
    always_comb begin
        o_alucontrol  = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_OR:  o_alucontrol = ALU_OR;
            ALUOP_FUNCT: begin
                case (i_funct)
                    F_ADD:   o_alucontrol = ALU_ADD;
                    F_SUB:   o_alucontrol = ALU_SUB;
                    F_AND:   o_alucontrol = ALU_AND;
                    F_OR:    o_alucontrol = ALU_OR;
                    F_SLT:   o_alucontrol = ALU_SLT;
                    default: begin
                        o_alucontrol  = ALU_ADD;
                        o_funct_valid = 1'b0;
                    end
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control sequencer with optional memory-ready stalls,
// per-instruction enables and a sticky illegal-instruction trap.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter logic EN_ORI        = 1'b1,
    parameter logic EN_BNE        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroext,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       r_illegal;
    logic       w_rdy;
    logic [1:0] w_aluop;
    logic       w_funct_valid;

    assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_alu_decode u_alu_decode (
        .i_aluop       (w_aluop),
        .i_funct       (funct),
        .o_alucontrol  (alucontrol),
        .o_funct_valid (w_funct_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sticky trap flag: raised on the edge that enters ILLEGAL
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_ILLEGAL) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_BNE:       w_next_state = EN_BNE ? S_BRANCH : S_ILLEGAL;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_ORI:       w_next_state = EN_ORI ? S_ORIEX : S_ILLEGAL;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    w_next_state = S_MEMWR;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMRD:   w_next_state = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = w_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next_state = w_funct_valid ? S_ALUWB : S_ILLEGAL;
            S_ALUWB:   w_next_state = S_FETCH;
            S_BRANCH:  w_next_state = S_FETCH;
            S_ADDIEX:  w_next_state = S_IWB;
            S_ORIEX:   w_next_state = S_IWB;
            S_IWB:     w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            S_ILLEGAL: w_next_state = S_ILLEGAL;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Per-state datapath strobes; only fetch/memory stalls and branches look past the state
    always_comb begin
        pcen     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        pcsrc    = PCSRC_ALU;
        zeroext  = 1'b0;
        w_aluop  = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = w_rdy;
                pcen    = w_rdy;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                if (op == OP_BEQ) begin
                    pcen = zero;
                end else if (op == OP_BNE && EN_BNE) begin
                    pcen = ~zero;
                end else begin
                    pcen = 1'b0;
                end
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_aluop = ALUOP_OR;
                zeroext = 1'b1;
            end
            S_IWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: pcen = 1'b0;
        endcase
    end

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a fully enabled handshaking instance and a
// non-handshaking instance with ORI/BNE disabled, checked cycle by cycle.
module tb_mc_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ORI = 6'b001101, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       sel_b;

    logic       pcen_a, memwrite_a, irwrite_a, regwrite_a, iord_a, regdst_a, memtoreg_a, alusrca_a, zeroext_a, illegal_a;
    logic [1:0] alusrcb_a, pcsrc_a;
    logic [2:0] alucontrol_a;
    logic [3:0] state_a;
    logic       pcen_b, memwrite_b, irwrite_b, regwrite_b, iord_b, regdst_b, memtoreg_b, alusrca_b, zeroext_b, illegal_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [2:0] alucontrol_b;
    logic [3:0] state_b;

    int n_vec = 0;
    int n_miscompare = 0;

    logic [20:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    mc_controller dut_a (
        .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen_a), .memwrite(memwrite_a), .irwrite(irwrite_a), .regwrite(regwrite_a),
        .iord(iord_a), .regdst(regdst_a), .memtoreg(memtoreg_a), .alusrca(alusrca_a),
        .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .zeroext(zeroext_a), .alucontrol(alucontrol_a),
        .illegal(illegal_a), .state(state_a)
    );

    mc_controller #(.MEM_HANDSHAKE(1'b0), .EN_ORI(1'b0), .EN_BNE(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regwrite(regwrite_b),
        .iord(iord_b), .regdst(regdst_b), .memtoreg(memtoreg_b), .alusrca(alusrca_b),
        .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .zeroext(zeroext_b), .alucontrol(alucontrol_b),
        .illegal(illegal_b), .state(state_b)
    );

    wire [20:0] w_vec_a = {pcen_a, memwrite_a, irwrite_a, regwrite_a, iord_a, regdst_a, memtoreg_a,
                           alusrca_a, alusrcb_a, pcsrc_a, zeroext_a, alucontrol_a, illegal_a, state_a};
    wire [20:0] w_vec_b = {pcen_b, memwrite_b, irwrite_b, regwrite_b, iord_b, regdst_b, memtoreg_b,
                           alusrca_b, alusrcb_b, pcsrc_b, zeroext_b, alucontrol_b, illegal_b, state_b};

    // Expected strobes for a given state, taken from the per-state control table
    function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] i_op, input logic [5:0] i_fn,
                                          input logic z, input logic rdy, input logic hs, input logic bne_en);
        logic pc = 1'b0, mw = 1'b0, ir = 1'b0, rw = 1'b0, io = 1'b0, rd = 1'b0, mr = 1'b0, sa = 1'b0;
        logic ze = 1'b0, il = 1'b0, r;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b010;
        r = hs ? rdy : 1'b1;
        case (st)
            4'd0:  begin sb = 2'b01; ir = r; pc = r; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin mr = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6: begin
                sa = 1'b1;
                case (i_fn)
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'b010;
                endcase
            end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8: begin
                sa = 1'b1; ac = 3'b110; ps = 2'b01;
                pc = (i_op == BEQ) ? z : ((i_op == BNE && bne_en) ? ~z : 1'b0);
            end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin ps = 2'b10; pc = 1'b1; end
            4'd12: begin sa = 1'b1; sb = 2'b10; ac = 3'b001; ze = 1'b1; end
            4'd13: il = 1'b1;
            default: il = 1'b0;
        endcase
        return {pc, mw, ir, rw, io, rd, mr, sa, sb, ps, ze, ac, il, st};
    endfunction

    task automatic check_value(input string tag, input logic [20:0] act, input logic [20:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %b, want %b (pcen,mw,irw,rw,iord,rdst,m2r,sa,sb,ps,zx,alu,ill,state)", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs, queue expectation, compare mid-cycle, advance
    task automatic step(input logic [5:0] i_op, input logic [5:0] i_fn, input logic i_z, input logic i_rdy,
                        input logic i_rst, input logic [3:0] exp_st, input string tag);
        op = i_op; funct = i_fn; zero = i_z; mem_ready = i_rdy;
        if (sel_b) reset_b = i_rst; else reset_a = i_rst;
        q_exp.push_back(model(exp_st, i_op, i_fn, i_z, i_rdy, ~sel_b, ~sel_b));
        q_tag.push_back(tag);
        @(negedge clk);
        check_value(q_tag.pop_front(), sel_b ? w_vec_b : w_vec_a, q_exp.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; sel_b = 1'b0;
        op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // LW, no stalls: 0,1,2,3,4
        for (int s = 0; s < 5; s++) step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'(s), "lw");
        // SW, three stall cycles in MEMWR
        step(SW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "sw_fetch");
        step(SW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "sw_decode");
        step(SW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd2, "sw_memadr");
        for (int s = 0; s < 3; s++) step(SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd5, "sw_stall");
        step(SW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd5, "sw_done");
        // BEQ/BNE with both zero values
        for (int b = 0; b < 4; b++) begin
            step(b < 2 ? BEQ : BNE, 6'd0, b[0], 1'b1, 1'b0, 4'd0, "br_fetch");
            step(b < 2 ? BEQ : BNE, 6'd0, b[0], 1'b1, 1'b0, 4'd1, "br_decode");
            step(b < 2 ? BEQ : BNE, 6'd0, b[0], 1'b1, 1'b0, 4'd8, "br_branch");
        end
        // ORI, ADDI, R-type slt/sub, J
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "ori_fetch");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "ori_decode");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd12, "ori_ex");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd10, "ori_wb");
        step(ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "addi_fetch");
        step(ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "addi_decode");
        step(ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd9, "addi_ex");
        step(ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd10, "addi_wb");
        step(RT, 6'b101010, 1'b0, 1'b1, 1'b0, 4'd0, "slt_fetch");
        step(RT, 6'b101010, 1'b0, 1'b1, 1'b0, 4'd1, "slt_decode");
        step(RT, 6'b101010, 1'b0, 1'b1, 1'b0, 4'd6, "slt_exec");
        step(RT, 6'b101010, 1'b0, 1'b1, 1'b0, 4'd7, "slt_aluwb");
        step(RT, 6'b100010, 1'b0, 1'b1, 1'b0, 4'd0, "sub_fetch");
        step(RT, 6'b100010, 1'b0, 1'b1, 1'b0, 4'd1, "sub_decode");
        step(RT, 6'b100010, 1'b0, 1'b1, 1'b0, 4'd6, "sub_exec");
        step(RT, 6'b100010, 1'b0, 1'b1, 1'b0, 4'd7, "sub_aluwb");
        step(JMP, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, "j_fetch_stall");
        step(JMP, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "j_fetch");
        step(JMP, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "j_decode");
        step(JMP, 6'd0, 1'b0, 1'b1, 1'b0, 4'd11, "j_jump");
        // Unknown funct traps; trap persists until reset
        step(RT, 6'b000000, 1'b0, 1'b1, 1'b0, 4'd0, "badf_fetch");
        step(RT, 6'b000000, 1'b0, 1'b1, 1'b0, 4'd1, "badf_decode");
        step(RT, 6'b000000, 1'b0, 1'b1, 1'b0, 4'd6, "badf_exec");
        for (int s = 0; s < 3; s++) step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd13, "trap_hold");
        step(LW, 6'd0, 1'b0, 1'b1, 1'b1, 4'd13, "trap_reset");
        // Reset during a fetch stall, then a stalled MEMRD
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, "rst_fstall");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd0, "rst_fstall_rst");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, "rst_fstall_after");
        step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "rst_fetch_go");
        step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "lws_decode");
        step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd2, "lws_memadr");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, "lws_memrd_stall");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b1, 4'd3, "lws_memrd_rst");
        step(LW, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "lws_after_rst");

        // Instance without handshake, ORI and BNE disabled
        reset_a = 1'b1;
        sel_b = 1'b1;
        for (int s = 0; s < 3; s++) step(SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'(s), "b_sw");
        step(SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd5, "b_sw_memwr");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, "b_lw_fetch");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd1, "b_lw_decode");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd2, "b_lw_memadr");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, "b_lw_memrd");
        step(LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd4, "b_lw_memwb");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "b_ori_fetch");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "b_ori_decode");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b0, 4'd13, "b_ori_trap");
        step(ORI, 6'd0, 1'b0, 1'b1, 1'b1, 4'd13, "b_ori_trap_rst");
        step(BNE, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, "b_bne_fetch");
        step(BNE, 6'd0, 1'b0, 1'b1, 1'b0, 4'd1, "b_bne_decode");
        step(BNE, 6'd0, 1'b0, 1'b1, 1'b0, 4'd13, "b_bne_trap");
        step(BNE, 6'd0, 1'b0, 1'b1, 1'b1, 4'd13, "b_bne_trap_rst");
        step(JMP, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, "b_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit. Replaces the single-cycle main/ALU decode pair for the shared-memory multicycle datapath.
- A state-machine sequencer issues per-cycle datapath strobes for LW, SW, R-type (add/sub/and/or/slt), BEQ, BNE, ADDI, ORI and J.
- Adds an optional memory-ready handshake, parametrised instruction enables, and sticky illegal-opcode trapping.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR stall until mem_ready; 0 = each is a single cycle and mem_ready is ignored.
- EN_ORI, 1, 1 = ORI (op 001101) supported; 0 = ORI is trapped as illegal.
- EN_BNE, 1, 1 = BNE (op 000101) supported; 0 = BNE is trapped as illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pcen  out  1  PC register enable.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- regdst  out  1  destination select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = data register, 0 = ALUOut.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = immext, 11 = immext<<2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- zeroext  out  1  immediate zero-extension select (ORI).
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  sticky trap flag.
- state  out  4  current state encoding (debug).

Behaviour:
- Reset: one cycle of reset forces state FETCH from any state, including mid-access stall and ILLEGAL.
- Outputs are combinational from state, op, funct, zero and mem_ready (Moore except the handshake/branch qualifiers).
- Every strobe not listed for a state is 0. alusrcb/pcsrc default 00; alucontrol defaults to add.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, IWB=10, JUMP=11, ORIEX=12, ILLEGAL=13. Codes 14 and 15 go to FETCH.
- Let rdy = mem_ready when MEM_HANDSHAKE=1, else 1.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite=rdy, pcen=rdy.
  - rdy -> DECODE, else stay.
- DECODE:
  - alusrca=0, alusrcb=11, add.
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 000101 -> BRANCH (if EN_BNE); 001000 -> ADDIEX; 001101 -> ORIEX (if EN_ORI); 000010 -> JUMP; any other -> ILLEGAL.
- MEMADR:
  - alusrca=1, alusrcb=10, add.
  - LW -> MEMRD; SW -> MEMWR.
- MEMRD: iord=1; rdy -> MEMWB, else stay.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
- MEMWR:
  - iord=1, memwrite=1, held high for every cycle of the stall.
  - rdy -> FETCH, else stay.
- EXECUTE:
  - alusrca=1, alusrcb=00.
  - alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> ILLEGAL (no ALUWB); otherwise -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero when op=000100; pcen = ~zero when op=000101.
  - -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, zeroext=0; -> IWB.
- ORIEX: alusrca=1, alusrcb=10, or, zeroext=1; -> IWB.
- IWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
- JUMP: pcsrc=10, pcen=1; -> FETCH.
- ILLEGAL:
  - All write enables 0, illegal=1.
  - Stays until reset.
  - illegal is registered: set on entry, cleared only by reset.
- CPI (no stalls): LW 5; SW, R-type, ADDI, ORI 4; BEQ, BNE, J 3. Each mem_ready=0 cycle adds one.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode and funct constants;
  - the 4-bit state localparams;
  - alucontrol codes;
  - alusrcb and pcsrc select codes.
- One sub-module, mc_alu_decode: combinational {aluop[1:0], funct} -> alucontrol plus funct_valid. The FSM instantiates it and uses funct_valid for the EXECUTE illegal path.

Test Plan:
- Reset, then LW (op=100011), mem_ready=1 -> states 0,1,2,3,4,0. irwrite=pcen=1 only in FETCH; regwrite=1 only in MEMWB with memtoreg=1.
- SW with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, iord=1 throughout, then FETCH. Repeat with MEM_HANDSHAKE=0 -> memwrite for 1 cycle.
- BEQ then BNE, each with zero=1 and zero=0 -> pcen in BRANCH is 1,0 for BEQ and 0,1 for BNE; alucontrol=110, pcsrc=01.
- ORI (op=001101), EN_ORI=1 -> ORIEX with alucontrol=001, zeroext=1, then IWB with regwrite=1, regdst=0. With EN_ORI=0 -> ILLEGAL, illegal=1, no regwrite.
- R-type funct=101010 -> alucontrol=111 in EXECUTE, ALUWB with regdst=1. funct=000000 -> ILLEGAL, state=13; illegal persists until reset pulse.
- Reset asserted during a FETCH stall (mem_ready=0) -> next cycle state=0, illegal=0, no pcen/irwrite glitch in the reset cycle's successor until mem_ready=1.
